mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-port 64kB behavioural memory between port 0 (CPU bus) and port 1 (DMA/loader).
- Latches one request at a time, drives the memory enable/address/write pins for exactly one cycle, waits out the memory read latency, and returns a one-cycle ack with read data to the granted port.
- Sits between the requesters and the memory instance; it is the only driver of the memory pins.

Parameters:
- ADDR_WIDTH, 16, address width; matches memory DEPTH.
- DATA_WIDTH, 8, data width; matches memory WIDTH.
- MEM_LATENCY, 1, cycles from the issue edge to memory rd_data valid; legal range 1..15.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held high with stable command until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse to port 0.
- p0_rdata  out  DATA_WIDTH  port 0 read data, valid when p0_ack=1 for a read.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1.
- mem_enable  out  1  to memory enable.
- mem_wr_enable  out  1  to memory wr_enable.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_wr_data  out  DATA_WIDTH  to memory wr_data.
- mem_rd_data  in  DATA_WIDTH  from memory rd_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. In reset, state=IDLE, every output is 0, last_grant=1 (so port 0 wins first under round-robin), and the read counter is 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, pick the winner and latch its we/addr/wdata into internal registers; go to ISSUE. Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high, FIXED_PRIORITY=1: port 0 wins.
  - Both high, FIXED_PRIORITY=0: the port other than last_grant wins.
  - last_grant updates on every grant.
- ISSUE (exactly 1 cycle): mem_enable=1, mem_wr_enable=latched we, mem_address and mem_wr_data from the latched command. Next state is DONE for a write. For a read, next state is WAIT with the counter loaded to MEM_LATENCY.
- WAIT: counter decrements each cycle. On the edge where counter==1, capture mem_rd_data into the granted port's rdata register, then go to DONE.
- DONE (1 cycle): the granted port's ack=1. For a read, its rdata holds the captured byte. The ungranted port's rdata is unchanged. Next state is IDLE.
- Memory pins are 0 in every state except ISSUE.
- Transaction length, req-sampled edge to ack cycle:
  - write: ISSUE, DONE = ack in the 2nd cycle after grant.
  - read: ISSUE, WAIT×MEM_LATENCY, DONE.
- Back-to-back: after DONE, one IDLE cycle re-arbitrates. A requester may change its command at the ack edge and keep req high to issue the next transaction.
- Requester command changes after grant are ignored, because the command is latched.
- req falling before ack is a protocol violation. The transaction completes anyway and ack is still pulsed.
- rdata registers hold their value between reads.
- A write never alters rdata.
- Reset mid-operation: the FSM returns to IDLE next cycle and no ack is generated. If reset coincides with the ISSUE cycle, the memory still samples that access (a write is performed); this is accepted.

Test Plan:
- Reset, then p0 write addr 0x1234 data 0xA5 -> mem_enable=1 and mem_wr_enable=1 for exactly one cycle with address 0x1234 and wr_data 0xA5; p0_ack pulses 2 cycles after grant; p1_ack stays 0.
- p1 read 0x1234 after the above, MEM_LATENCY=1 -> p1_ack pulses 3 cycles after grant with p1_rdata=0xA5; p0_rdata unchanged.
- FIXED_PRIORITY=0, p0 and p1 both hold req for 4 reads each -> grant order p0,p1,p0,p1,…; each port receives exactly 4 acks.
- FIXED_PRIORITY=1, both reqs held continuously -> port 0 receives every grant and p1_ack never pulses (starvation is expected).
- MEM_LATENCY=3, read of a preloaded byte 0x3C -> ack 5 cycles after grant with rdata=0x3C; mem pins are 0 in all WAIT cycles.
- Reset asserted during WAIT of a p0 read -> no p0_ack, busy=0 the next cycle; a subsequent p1 write is granted and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port memory: grants one request at a time,
// issues it for one cycle, waits out the read latency and returns a one-cycle ack with data.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_LATENCY    = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic                  mem_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,

    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);

    state_t                state_reg, state_next;
    logic                  last_grant_reg, last_grant_next;
    logic [3:0]            count_reg, count_next;
    logic                  mem_enable_reg, mem_enable_next;
    logic                  mem_wr_enable_reg, mem_wr_enable_next;
    logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
    logic [DATA_WIDTH-1:0] mem_wr_data_reg, mem_wr_data_next;
    logic                  busy_reg, busy_next;
    logic [1:0]            ack_next;
    logic [1:0]            capture_next;
    logic                  win;

    // Round-robin gives the tie to the port that was not served last.
    always_comb begin
        if (p0_req && p1_req) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_reg;
        end else begin
            win = p1_req;
        end
    end

    // The pin registers are loaded at grant and double as the latched command during ISSUE.
    always_comb begin
        state_next         = state_reg;
        last_grant_next    = last_grant_reg;
        count_next         = count_reg;
        mem_enable_next    = 1'b0;
        mem_wr_enable_next = 1'b0;
        mem_address_next   = '0;
        mem_wr_data_next   = '0;
        ack_next           = '0;
        capture_next       = '0;

        unique case (state_reg)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_next         = ISSUE;
                    last_grant_next    = win;
                    mem_enable_next    = 1'b1;
                    mem_wr_enable_next = win ? p1_we    : p0_we;
                    mem_address_next   = win ? p1_addr  : p0_addr;
                    mem_wr_data_next   = win ? p1_wdata : p0_wdata;
                end
            end
            ISSUE: begin
                if (mem_wr_enable_reg) begin
                    state_next               = DONE;
                    ack_next[last_grant_reg] = 1'b1;
                end else begin
                    state_next = WAIT;
                    count_next = LATENCY_LOAD;
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next                   = DONE;
                    ack_next[last_grant_reg]     = 1'b1;
                    capture_next[last_grant_reg] = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            last_grant_reg    <= 1'b1;
            count_reg         <= '0;
            mem_enable_reg    <= 1'b0;
            mem_wr_enable_reg <= 1'b0;
            mem_address_reg   <= '0;
            mem_wr_data_reg   <= '0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            last_grant_reg    <= last_grant_next;
            count_reg         <= count_next;
            mem_enable_reg    <= mem_enable_next;
            mem_wr_enable_reg <= mem_wr_enable_next;
            mem_address_reg   <= mem_address_next;
            mem_wr_data_reg   <= mem_wr_data_next;
            busy_reg          <= busy_next;
        end
    end

    logic [1:0]            ack_out;
    logic [DATA_WIDTH-1:0] rdata_out [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic                  ack_reg;
        logic [DATA_WIDTH-1:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= ack_next[gi];
                if (capture_next[gi]) begin
                    rdata_reg <= mem_rd_data;
                end
            end
        end

        assign ack_out[gi]   = ack_reg;
        assign rdata_out[gi] = rdata_reg;
    end

    assign p0_ack        = ack_out[0];
    assign p1_ack        = ack_out[1];
    assign p0_rdata      = rdata_out[0];
    assign p1_rdata      = rdata_out[1];
    assign mem_enable    = mem_enable_reg;
    assign mem_wr_enable = mem_wr_enable_reg;
    assign mem_address   = mem_address_reg;
    assign mem_wr_data   = mem_wr_data_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A (round-robin, latency 1) and
// instance B (fixed priority, latency 3), each with its own behavioural memory.
module tb_mem_arbiter;

    localparam int B_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_p0_req, a_p0_we, a_p0_ack, a_p1_req, a_p1_we, a_p1_ack;
    logic [15:0] a_p0_addr, a_p1_addr, a_mem_address;
    logic [7:0]  a_p0_wdata, a_p0_rdata, a_p1_wdata, a_p1_rdata;
    logic        a_mem_enable, a_mem_wr_enable, a_busy;
    logic [7:0]  a_mem_wr_data, a_mem_rd_data;

    logic        b_p0_req, b_p0_we, b_p0_ack, b_p1_req, b_p1_we, b_p1_ack;
    logic [15:0] b_p0_addr, b_p1_addr, b_mem_address;
    logic [7:0]  b_p0_wdata, b_p0_rdata, b_p1_wdata, b_p1_rdata;
    logic        b_mem_enable, b_mem_wr_enable, b_busy;
    logic [7:0]  b_mem_wr_data, b_mem_rd_data;

    logic        b_load;
    logic [15:0] b_load_addr;
    logic [7:0]  b_load_data;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1), .FIXED_PRIORITY(0)) dut_a (
        .clk(clk), .reset(reset),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
        .mem_enable(a_mem_enable), .mem_wr_enable(a_mem_wr_enable), .mem_address(a_mem_address),
        .mem_wr_data(a_mem_wr_data), .mem_rd_data(a_mem_rd_data), .busy(a_busy)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(B_LAT), .FIXED_PRIORITY(1)) dut_b (
        .clk(clk), .reset(reset),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .mem_enable(b_mem_enable), .mem_wr_enable(b_mem_wr_enable), .mem_address(b_mem_address),
        .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data), .busy(b_busy)
    );

    // Behavioural memories: read data appears MEM_LATENCY cycles after the issue edge.
    logic [7:0] mem_a [65536];
    logic [7:0] a_pipe;
    always @(posedge clk) begin
        if (a_mem_enable && a_mem_wr_enable) mem_a[a_mem_address] <= a_mem_wr_data;
        if (a_mem_enable && !a_mem_wr_enable) a_pipe <= mem_a[a_mem_address];
    end
    assign a_mem_rd_data = a_pipe;

    logic [7:0] mem_b [65536];
    logic [7:0] b_pipe [B_LAT];
    always @(posedge clk) begin
        if (b_load) mem_b[b_load_addr] <= b_load_data;
        if (b_mem_enable && b_mem_wr_enable) mem_b[b_mem_address] <= b_mem_wr_data;
        if (b_mem_enable && !b_mem_wr_enable) b_pipe[0] <= mem_b[b_mem_address];
        for (int i = 1; i < B_LAT; i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign b_mem_rd_data = b_pipe[B_LAT-1];

    int vectors = 0;
    int miscompares = 0;
    int a_ack0 = 0, a_ack1 = 0, a_en = 0, b_ack0 = 0, b_ack1 = 0;

    always @(posedge clk) begin
        if (a_p0_ack) a_ack0++;
        if (a_p1_ack) a_ack1++;
        if (a_mem_enable) a_en++;
        if (b_p0_ack) b_ack0++;
        if (b_p1_ack) b_ack1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance A, starting from IDLE on a falling edge.
    task automatic a_xact(input bit port, input logic we, input logic [15:0] addr,
                          input logic [7:0] wdata, input int exp_lat,
                          input logic [7:0] exp_rdata, input string tag);
        int         n;
        bit         got;
        int         ack0_was, ack1_was, en_was;
        logic [7:0] other_was;
        ack0_was  = a_ack0;
        ack1_was  = a_ack1;
        en_was    = a_en;
        other_was = port ? a_p0_rdata : a_p1_rdata;
        if (port) begin
            a_p1_req = 1'b1; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wdata;
        end else begin
            a_p0_req = 1'b1; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wdata;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, " issue en"},    32'(a_mem_enable),    32'd1);
                check({tag, " issue wr_en"}, 32'(a_mem_wr_enable), 32'(we));
                check({tag, " issue addr"},  32'(a_mem_address),   32'(addr));
                check({tag, " issue wdata"}, 32'(a_mem_wr_data),   32'(wdata));
            end
            got = port ? a_p1_ack : a_p0_ack;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        if (!we) check({tag, " rdata"}, 32'(port ? a_p1_rdata : a_p0_rdata), 32'(exp_rdata));
        check({tag, " other rdata"}, 32'(port ? a_p0_rdata : a_p1_rdata), 32'(other_was));
        a_p0_req = 1'b0;
        a_p1_req = 1'b0;
        @(negedge clk);
        check({tag, " ack count"},       32'(port ? a_ack1 - ack1_was : a_ack0 - ack0_was), 32'd1);
        check({tag, " other ack count"}, 32'(port ? a_ack0 - ack0_was : a_ack1 - ack1_was), 32'd0);
        check({tag, " issue count"},     32'(a_en - en_was), 32'd1);
        check({tag, " busy after"},      32'(a_busy), 32'd0);
        $display("xact %s: port %0d we %0d addr %h latency %0d", tag, port, we, addr, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit got;
        int p0_idx, p1_idx, ack_no, ack0_was, b0_was, b1_was;

        reset = 1'b1;
        a_p0_req = 0; a_p0_we = 0; a_p0_addr = '0; a_p0_wdata = '0;
        a_p1_req = 0; a_p1_we = 0; a_p1_addr = '0; a_p1_wdata = '0;
        b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0;
        b_load = 0; b_load_addr = '0; b_load_data = '0;
        repeat (2) @(negedge clk);
        check("reset busy",     32'(a_busy),       32'd0);
        check("reset ack",      32'(a_p0_ack),     32'd0);
        check("reset mem_en",   32'(a_mem_enable), 32'd0);
        check("reset rdata",    32'(a_p0_rdata),   32'd0);
        check("reset b busy",   32'(b_busy),       32'd0);
        reset = 1'b0;
        @(negedge clk);

        a_xact(1'b0, 1'b1, 16'h1234, 8'hA5, 2, 8'h00, "p0 wr 1234");
        check("mem 1234", 32'(mem_a[16'h1234]), 32'h0000_00A5);
        a_xact(1'b0, 1'b1, 16'h0042, 8'h5A, 2, 8'h00, "p0 wr 42");
        a_xact(1'b0, 1'b0, 16'h0042, 8'hEE, 3, 8'h5A, "p0 rd 42");
        a_xact(1'b0, 1'b1, 16'h0042, 8'h77, 2, 8'h00, "p0 wr 42 again");
        check("write keeps rdata", 32'(a_p0_rdata), 32'h0000_005A);

        for (int i = 0; i < 4; i++) begin
            a_xact(1'b1, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i), 2, 8'h00, "p1 load p0 area");
            a_xact(1'b1, 1'b1, 16'h0200 + 16'(i), 8'h20 + 8'(i), 2, 8'h00, "p1 load p1 area");
        end
        a_xact(1'b1, 1'b0, 16'h1234, 8'hEE, 3, 8'hA5, "p1 rd 1234");

        // Both ports hold req for four reads each; grants must alternate starting at port 0.
        p0_idx = 0; p1_idx = 0; ack_no = 0;
        a_p0_req = 1; a_p0_we = 0; a_p0_addr = 16'h0100;
        a_p1_req = 1; a_p1_we = 0; a_p1_addr = 16'h0200;
        for (int c = 0; c < 60 && (a_p0_req || a_p1_req); c++) begin
            @(negedge clk);
            if (a_p0_ack) begin
                check("rr order p0", 32'(ack_no % 2), 32'd0);
                check("rr p0 rdata", 32'(a_p0_rdata), 32'h10 + 32'(p0_idx));
                $display("rr grant %0d -> port 0 rdata %h", ack_no, a_p0_rdata);
                p0_idx++; ack_no++;
                if (p0_idx == 4) a_p0_req = 1'b0;
                else a_p0_addr = 16'h0100 + 16'(p0_idx);
            end
            if (a_p1_ack) begin
                check("rr order p1", 32'(ack_no % 2), 32'd1);
                check("rr p1 rdata", 32'(a_p1_rdata), 32'h20 + 32'(p1_idx));
                $display("rr grant %0d -> port 1 rdata %h", ack_no, a_p1_rdata);
                p1_idx++; ack_no++;
                if (p1_idx == 4) a_p1_req = 1'b0;
                else a_p1_addr = 16'h0200 + 16'(p1_idx);
            end
        end
        check("rr p0 acks", 32'(p0_idx), 32'd4);
        check("rr p1 acks", 32'(p1_idx), 32'd4);
        a_p0_req = 0; a_p1_req = 0;
        @(negedge clk);

        // Reset while a port 0 read sits in WAIT: no ack, FSM back to IDLE.
        a_p0_req = 1; a_p0_we = 0; a_p0_addr = 16'h1234; a_p0_wdata = 8'h00;
        @(negedge clk);
        check("rst issue busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        check("rst wait busy", 32'(a_busy), 32'd1);
        check("rst wait ack",  32'(a_p0_ack), 32'd0);
        ack0_was = a_ack0;
        reset = 1'b1;
        @(negedge clk);
        check("rst busy",   32'(a_busy),       32'd0);
        check("rst ack",    32'(a_p0_ack),     32'd0);
        check("rst rdata",  32'(a_p0_rdata),   32'd0);
        check("rst mem_en", 32'(a_mem_enable), 32'd0);
        reset = 1'b0;
        a_p0_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst no late ack", 32'(a_ack0 - ack0_was), 32'd0);
        $display("reset during wait: busy %0d ack %0d", a_busy, a_p0_ack);
        a_xact(1'b1, 1'b1, 16'h5555, 8'h99, 2, 8'h00, "p1 wr after reset");
        check("mem 5555", 32'(mem_a[16'h5555]), 32'h0000_0099);

        // Instance B: latency 3 read, then fixed-priority starvation.
        b_load = 1; b_load_addr = 16'h0777; b_load_data = 8'h3C;
        @(negedge clk);
        b_load_addr = 16'h0010; b_load_data = 8'hC3;
        @(negedge clk);
        b_load = 0;
        b_p1_req = 1; b_p1_we = 0; b_p1_addr = 16'h0777; b_p1_wdata = 8'h00;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("b issue en", 32'(b_mem_enable), 32'd1);
                check("b issue addr", 32'(b_mem_address), 32'h0000_0777);
            end else if (n <= 4) begin
                check("b wait en",    32'(b_mem_enable),    32'd0);
                check("b wait wr_en", 32'(b_mem_wr_enable), 32'd0);
                check("b wait addr",  32'(b_mem_address),   32'd0);
                check("b wait busy",  32'(b_busy),          32'd1);
            end
            got = b_p1_ack;
        end
        check("b latency", 32'(n), 32'd5);
        check("b p1 rdata", 32'(b_p1_rdata), 32'h0000_003C);
        check("b p0 rdata untouched", 32'(b_p0_rdata), 32'd0);
        $display("xact b p1 rd 0777: latency %0d rdata %h", n, b_p1_rdata);
        b_p1_req = 0;
        @(negedge clk);

        b0_was = b_ack0; b1_was = b_ack1;
        b_p0_req = 1; b_p0_we = 0; b_p0_addr = 16'h0010;
        b_p1_req = 1; b_p1_we = 0; b_p1_addr = 16'h0777;
        repeat (30) @(negedge clk);
        check("b fixed p0 acks", 32'(b_ack0 - b0_was), 32'd5);
        check("b fixed p1 acks", 32'(b_ack1 - b1_was), 32'd0);
        check("b fixed p0 rdata", 32'(b_p0_rdata), 32'h0000_00C3);
        check("b fixed p1 rdata held", 32'(b_p1_rdata), 32'h0000_003C);
        $display("b fixed priority: p0 acks %0d p1 acks %0d", b_ack0 - b0_was, b_ack1 - b1_was);
        b_p0_req = 0; b_p1_req = 0;
        @(negedge clk);
        check("b idle busy", 32'(b_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
